mdu_unit: RTL and testbench

//  Parametrised iterative RV M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) for the OoO execution stage.

---
 rtl/rv32i_types_pkg.sv | 38 +++
 rtl/mdu_sign_fixup.sv | 13 +
 rtl/mdu_unit.sv | 213 +++++++++++++++++++++
 tb/tb_mdu_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types_pkg.sv
// Shared M-extension types: op encodings, MDU FSM states, result bundle.
// Operand signedness helpers used by the MDU issue decode.
package rv32i_types;

    localparam int MDU_XLEN     = 32;
    localparam int MDU_ROB_ID_W = 5;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    typedef struct packed {
        logic [MDU_ROB_ID_W-1:0] rob_id;
        logic [MDU_XLEN-1:0]     data;
    } mdu_out_t;

    function automatic logic op_a_signed(input mdu_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_b_signed(input mdu_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/mdu_sign_fixup.sv
// Conditional two's-complement negate: magnitude in, signed value out.
// Serves both operand magnitude extraction and result sign restore.
module mdu_sign_fixup #(
    parameter int W = 32
) (
    input  logic [W-1:0] mag,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (~mag + W'(1)) : mag;

endmodule

// File: rtl/mdu_unit.sv
// Iterative RV M-extension unit: radix-2 multiply, optional restoring divide.
// Divider datapath present only when MDU_DIV_EN is defined.
module mdu_unit
    import rv32i_types::*;
#(
    parameter  int XLEN     = 32,
    parameter  int ROB_ID_W = 5,
    localparam int CNT_W    = $clog2(XLEN) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_funct3,
    input  logic [XLEN-1:0]     in_rs1_v,
    input  logic [XLEN-1:0]     in_rs2_v,
    input  logic [ROB_ID_W-1:0] in_rob_id,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ROB_ID_W-1:0] out_rob_id,
    output logic [XLEN-1:0]     out_data
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef struct packed {
        logic [ROB_ID_W-1:0] rob_id;
        logic [XLEN-1:0]     data;
    } out_t;

    mdu_state_t          state;
    mdu_op_t             op_q;
    mdu_op_t             in_op;
    logic [XLEN-1:0]     hi_q, lo_q, b_q;
    logic [ROB_ID_W-1:0] rob_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                neg_q;
    logic                spec_q;
    logic                out_valid_q;
    out_t                out_q;

    logic                a_sgn, b_sgn;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                special;
    logic [XLEN-1:0]     spec_data;
    logic [XLEN:0]       mul_sum;
    logic [XLEN-1:0]     mul_hi, mul_lo;
    logic [XLEN-1:0]     hi_nxt, lo_nxt;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     mul_res;
    logic [XLEN-1:0]     fin_data;

    assign in_op     = mdu_op_t'(in_funct3);
    assign a_sgn     = op_a_signed(in_op) & in_rs1_v[XLEN-1];
    assign b_sgn     = op_b_signed(in_op) & in_rs2_v[XLEN-1];
    assign in_ready  = (state == IDLE) && !flush && !rst;
    assign out_valid = out_valid_q;
    assign out_rob_id = out_q.rob_id;
    assign out_data  = out_q.data;

    mdu_sign_fixup #(.W(XLEN)) u_fix_a (
        .mag (in_rs1_v),
        .neg (a_sgn),
        .res (a_mag)
    );

    mdu_sign_fixup #(.W(XLEN)) u_fix_b (
        .mag (in_rs2_v),
        .neg (b_sgn),
        .res (b_mag)
    );

    // One shift-add step; the adder carry becomes the new product MSB.
    assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : {XLEN{1'b0}})};
    assign mul_hi  = mul_sum[XLEN:1];
    assign mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};

    mdu_sign_fixup #(.W(2*XLEN)) u_fix_p (
        .mag ({hi_q, lo_q}),
        .neg (neg_q),
        .res (prod)
    );

    assign mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0]
                                      : prod[2*XLEN-1:XLEN];

`ifdef MDU_DIV_EN
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic            neg_r_q;
    logic            div0, ovf;
    logic [XLEN:0]   r_sh, r_diff;
    logic            q_bit;
    logic [XLEN-1:0] div_hi, div_lo;
    logic [XLEN-1:0] quo, rem;

    always_comb begin
        div0 = in_funct3[2] && (in_rs2_v == '0);
        ovf  = ((in_op == OP_DIV) || (in_op == OP_REM))
            && (in_rs1_v == INT_MIN) && (&in_rs2_v);
        special = div0 | ovf;
        if (div0) begin
            spec_data = in_funct3[1] ? in_rs1_v : '1;
        end else begin
            spec_data = in_funct3[1] ? '0 : in_rs1_v;
        end
    end

    // Restoring step: remainder in hi, dividend shifts out of lo, quotient in.
    assign r_sh   = {hi_q, lo_q[XLEN-1]};
    assign r_diff = r_sh - {1'b0, b_q};
    assign q_bit  = ~r_diff[XLEN];
    assign div_hi = q_bit ? r_diff[XLEN-1:0] : r_sh[XLEN-1:0];
    assign div_lo = {lo_q[XLEN-2:0], q_bit};

    assign hi_nxt = op_q[2] ? div_hi : mul_hi;
    assign lo_nxt = op_q[2] ? div_lo : mul_lo;

    mdu_sign_fixup #(.W(XLEN)) u_fix_q (
        .mag (lo_q),
        .neg (neg_q),
        .res (quo)
    );

    mdu_sign_fixup #(.W(XLEN)) u_fix_r (
        .mag (hi_q),
        .neg (neg_r_q),
        .res (rem)
    );

    always_comb begin
        if (spec_q) begin
            fin_data = lo_q;
        end else if (op_q[2]) begin
            fin_data = op_q[1] ? rem : quo;
        end else begin
            fin_data = mul_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_r_q <= 1'b0;
        end else if (!flush && (state == IDLE) && in_valid) begin
            neg_r_q <= a_sgn;
        end
    end
`else
    assign special   = in_funct3[2];
    assign spec_data = '0;
    assign hi_nxt    = mul_hi;
    assign lo_nxt    = mul_lo;
    assign fin_data  = spec_q ? lo_q : mul_res;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= OP_MUL;
            hi_q        <= '0;
            lo_q        <= '0;
            b_q         <= '0;
            rob_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            spec_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (flush) begin
            state       <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q   <= in_op;
                        rob_q  <= in_rob_id;
                        cnt_q  <= '0;
                        hi_q   <= '0;
                        lo_q   <= special ? spec_data : a_mag;
                        b_q    <= b_mag;
                        neg_q  <= a_sgn ^ b_sgn;
                        spec_q <= special;
                        state  <= special ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    hi_q  <= hi_nxt;
                    lo_q  <= lo_nxt;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle applies the sign fixup into out_q.
                    if (!out_valid_q) begin
                        out_valid_q  <= 1'b1;
                        out_q.rob_id <= rob_q;
                        out_q.data   <= fin_data;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit at XLEN=32: ops, specials, backpressure, flush, reset.
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic [31:0] in_rs1_v;
    logic [31:0] in_rs2_v;
    logic [4:0]  in_rob_id;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rob_id;
    logic [31:0] out_data;

    int checks = 0;
    int failures = 0;

    mdu_unit #(.XLEN(32), .ROB_ID_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_funct3  (in_funct3),
        .in_rs1_v   (in_rs1_v),
        .in_rs2_v   (in_rs2_v),
        .in_rob_id  (in_rob_id),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rob_id (out_rob_id),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rob);
        in_valid  = 1'b1;
        in_funct3 = f;
        in_rs1_v  = a;
        in_rs2_v  = b;
        in_rob_id = rob;
    endtask

    task automatic wait_valid(input string tag, input int lat);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(lat));
    endtask

    task automatic run_op(input string tag, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rob, input logic [31:0] exp,
                          input int lat);
        @(negedge clk);
        out_ready = 1'b1;
        issue(f, a, b, rob);
        #1;
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(tag, lat);
        check({tag, "_data"}, out_data, exp);
        check({tag, "_rob"}, 32'(out_rob_id), 32'(rob));
        @(posedge clk);
        #1;
        check({tag, "_retire"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        bit seen;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_funct3 = 3'd0;
        in_rs1_v  = '0;
        in_rs2_v  = '0;
        in_rob_id = '0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", 32'(in_ready), 32'd0);
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_rob", 32'(out_rob_id), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_rdy", 32'(in_ready), 32'd1);

        run_op("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd4, 32'hFFFFFFEB, 33);
        run_op("mulh_min", 3'd1, 32'h80000000, 32'h80000000, 5'd5,
               32'h40000000, 33);
        run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,
               32'hFFFFFFFF, 33);
        run_op("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,
               32'hFFFFFFFE, 33);
        run_op("mulh_neg", 3'd1, 32'hFFFFFFF9, 32'd3, 5'd8,
               32'hFFFFFFFF, 33);
        run_op("mul_wrap", 3'd0, 32'h00010000, 32'h00010000, 5'd9,
               32'h0, 33);
        run_op("mulhu_carry", 3'd3, 32'h80000000, 32'd2, 5'd10,
               32'd1, 33);

`ifdef MDU_DIV_EN
        run_op("div", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd11, 32'hFFFFFFFD, 33);
        run_op("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd12, 32'hFFFFFFFF, 33);
        run_op("divu", 3'd5, 32'd100, 32'd7, 5'd13, 32'd14, 33);
        run_op("remu", 3'd7, 32'd100, 32'd7, 5'd14, 32'd2, 33);
        run_op("div_z", 3'd4, 32'd5, 32'd0, 5'd15, 32'hFFFFFFFF, 1);
        run_op("rem_z", 3'd6, 32'd5, 32'd0, 5'd16, 32'd5, 1);
        run_op("divu_z", 3'd5, 32'd5, 32'd0, 5'd17, 32'hFFFFFFFF, 1);
        run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd18,
               32'h80000000, 1);
        run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd19,
               32'd0, 1);
`else
        run_op("div_off", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd11, 32'd0, 1);
        run_op("rem_off", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd12, 32'd0, 1);
        run_op("divu_off", 3'd5, 32'd100, 32'd7, 5'd13, 32'd0, 1);
        run_op("remu_off", 3'd7, 32'd5, 32'd0, 5'd14, 32'd0, 1);
`endif

        // Backpressure: result held for 10 cycles while new issues are refused.
        @(negedge clk);
        out_ready = 1'b0;
        issue(3'd0, 32'd6, 32'd7, 5'd9);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid("bp", 33);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            issue(3'd4, 32'd5, 32'd0, 5'd3);
            #1;
            check("bp_rdy", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            check("bp_vld", 32'(out_valid), 32'd1);
            check("bp_data", out_data, 32'd42);
            check("bp_rob", 32'(out_rob_id), 32'd9);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_retire", 32'(out_valid), 32'd0);
        check("bp_idle", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_ghost", 32'(out_valid), 32'd0);

        // Flush sampled at T+10 of a MUL, with a competing issue that must drop.
        @(negedge clk);
        issue(3'd0, 32'd3, 32'd3, 5'd21);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        issue(3'd0, 32'd2, 32'd2, 5'd22);
        #1;
        check("fl_rdy_blk", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("fl_vld", 32'(out_valid), 32'd0);
        check("fl_idle", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("fl_never", 32'(seen), 32'd0);

        // Reset in the middle of BUSY; out_data still holds 42 beforehand.
        @(negedge clk);
        issue(3'd0, 32'd5, 32'd5, 5'd23);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mrst_rdy", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_vld", 32'(out_valid), 32'd0);
        check("mrst_data", out_data, 32'd0);
        check("mrst_rob", 32'(out_rob_id), 32'd0);
        #1;
        check("mrst_idle", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("mrst_never", 32'(seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
